// File: rtl/uart_transmitter.sv
// UART transmit serializer: takes one word per valid/ready handshake and sends it
// LSB first as a start bit, data bits, an optional parity bit and 1 or 2 stop bits.
module uart_transmitter #(
  parameter int DIV_SIZE  = 16,
  parameter int DATA_UART = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic                 stop_bits_i,
  input  logic                 parity_bit_i,
  input  logic                 parity_odd_i,
  input  logic [DIV_SIZE-1:0]  baud_div_i,
  input  logic [DATA_UART-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic                 tx_o
);

  localparam int CNT_W = (DATA_UART > 2) ? $clog2(DATA_UART) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_SIZE-1:0]  cnt_q, cnt_d;
  logic [DIV_SIZE-1:0]  last_q, last_d;      // bit period minus one, latched at accept
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_UART-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_flag_q, stop_flag_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic bit_end;
  logic accept;

  assign tx_ready_o = (state_q == IDLE) & en_i;
  assign accept     = tx_valid_i & tx_ready_o;
  assign bit_end    = (cnt_q == last_q);
  assign tx_o       = tx_q;
  assign tx_busy_o  = busy_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values of the previous cycle regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      stop_flag_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      par_en_q    <= par_en_d;
      stop2_q     <= stop2_d;
      stop_flag_q <= stop_flag_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: every signal driven here gets its hold value first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    stop_flag_d = stop_flag_q;
    tx_d        = tx_q;
    busy_d      = busy_q;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + DIV_SIZE'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          state_d     = START;
          cnt_d       = '0;
          // A divisor of zero behaves as one clock per bit.
          last_d      = (baud_div_i == '0) ? '0 : baud_div_i - DIV_SIZE'(1);
          bitcnt_d    = '0;
          shift_d     = tx_data_i;
          par_d       = ^tx_data_i ^ parity_odd_i;
          par_en_d    = parity_bit_i;
          stop2_d     = stop_bits_i;
          stop_flag_d = 1'b0;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_d  = shift_q >> 1;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == CNT_W'(DATA_UART - 1)) begin
            bitcnt_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop2_q && !stop_flag_q) begin
            stop_flag_d = 1'b1;
          end else begin
            state_d     = IDLE;
            stop_flag_d = 1'b0;
            busy_d      = 1'b0;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        stop_flag_d = 1'b0;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frames are checked clock by clock against
// a bit list built from the word and line format in the bench itself.
module tb_uart_transmitter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        en_i;
  logic        stop_bits_i;
  logic        parity_bit_i;
  logic        parity_odd_i;
  logic [15:0] baud_div_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        tx_busy_o;
  logic        tx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  uart_transmitter #(.DIV_SIZE(16), .DATA_UART(8)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (en_i),
    .stop_bits_i  (stop_bits_i),
    .parity_bit_i (parity_bit_i),
    .parity_odd_i (parity_odd_i),
    .baud_div_i   (baud_div_i),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_busy_o    (tx_busy_o),
    .tx_o         (tx_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a word with its line format and return at the first negedge after the accept edge.
  task automatic start_frame(input logic [7:0] d, input int div, input bit pe, input bit po,
                             input bit ts, input string tag);
    int waited;
    tx_data_i    = d;
    baud_div_i   = 16'(div);
    parity_bit_i = pe;
    parity_odd_i = po;
    stop_bits_i  = ts;
    tx_valid_i   = 1'b1;
    waited       = 0;
    while (!tx_ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    check({tag, "_ready"}, 32'(tx_ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Sample the whole frame one clock at a time, then the idle clock after it.
  // At sample chg_at the divisor and parity enable are changed mid-frame.
  task automatic expect_frame(input logic [7:0] d, input int div, input bit pe, input bit po,
                              input bit ts, input string tag, input int chg_at);
    int p;
    int n;
    bit exp_bits[$];
    p = (div == 0) ? 1 : div;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (pe) exp_bits.push_back(^d ^ po);
    exp_bits.push_back(1'b1);
    if (ts) exp_bits.push_back(1'b1);
    n = exp_bits.size();
    for (int k = 0; k < n * p; k++) begin
      if (k > 0) @(negedge clk_i);
      if (k == chg_at) begin
        baud_div_i   = 16'd8;
        parity_bit_i = 1'b1;
      end
      check($sformatf("%s_bit%0d_clk%0d", tag, k / p, k % p),
            {29'd0, tx_ready_o, tx_busy_o, tx_o}, {29'd0, 1'b0, 1'b1, exp_bits[k / p]});
    end
    @(negedge clk_i);
    check({tag, "_idle"}, {29'd0, tx_ready_o, tx_busy_o, tx_o}, {29'd0, en_i, 1'b0, 1'b1});
  endtask

  initial begin
    rstn_i       = 1'b0;
    en_i         = 1'b0;
    stop_bits_i  = 1'b0;
    parity_bit_i = 1'b0;
    parity_odd_i = 1'b0;
    baud_div_i   = 16'd4;
    tx_data_i    = 8'h00;
    tx_valid_i   = 1'b0;

    repeat (3) @(negedge clk_i);
    check("reset_state", {29'd0, tx_ready_o, tx_busy_o, tx_o}, 32'b001);
    rstn_i = 1'b1;
    en_i   = 1'b1;
    @(negedge clk_i);
    check("after_reset", {29'd0, tx_ready_o, tx_busy_o, tx_o}, 32'b101);

    // 8N1, divisor 4: 40 clocks
    start_frame(8'hA5, 4, 0, 0, 0, "t1");
    tx_valid_i = 1'b0;
    expect_frame(8'hA5, 4, 0, 0, 0, "t1", -1);

    // Even then odd parity with two stop bits, divisor 3: 36 clocks each
    start_frame(8'h07, 3, 1, 0, 1, "t2e");
    tx_valid_i = 1'b0;
    expect_frame(8'h07, 3, 1, 0, 1, "t2e", -1);
    start_frame(8'h07, 3, 1, 1, 1, "t2o");
    tx_valid_i = 1'b0;
    expect_frame(8'h07, 3, 1, 1, 1, "t2o", -1);

    // Back-to-back with valid held high
    start_frame(8'h55, 2, 0, 0, 0, "t3a");
    tx_data_i = 8'hAA;
    expect_frame(8'h55, 2, 0, 0, 0, "t3a", -1);
    @(posedge clk_i);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    expect_frame(8'hAA, 2, 0, 0, 0, "t3b", -1);

    // Config changes mid-frame only affect the next frame
    start_frame(8'h3C, 4, 0, 0, 0, "t4a");
    tx_valid_i = 1'b0;
    expect_frame(8'h3C, 4, 0, 0, 0, "t4a", 10);
    start_frame(8'hC3, 8, 1, 0, 0, "t4b");
    tx_valid_i = 1'b0;
    expect_frame(8'hC3, 8, 1, 0, 0, "t4b", -1);

    // Asynchronous reset during DATA
    start_frame(8'h00, 4, 0, 0, 0, "t5");
    tx_valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("t5_in_data", {30'd0, tx_busy_o, tx_o}, 32'b10);
    #2;
    rstn_i = 1'b0;
    #1;
    check("t5_async_reset", {30'd0, tx_busy_o, tx_o}, 32'b01);
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    check("t5_after_release", {29'd0, tx_ready_o, tx_busy_o, tx_o}, {29'd0, en_i, 1'b0, 1'b1});
    start_frame(8'h5A, 4, 0, 0, 0, "t5b");
    tx_valid_i = 1'b0;
    expect_frame(8'h5A, 4, 0, 0, 0, "t5b", -1);

    // Disabled: valid is ignored
    en_i       = 1'b0;
    tx_data_i  = 8'h00;
    tx_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk_i);
      check($sformatf("t6_disabled_%0d", i), {29'd0, tx_ready_o, tx_busy_o, tx_o}, 32'b001);
    end
    tx_valid_i = 1'b0;
    en_i       = 1'b1;

    // Divisor 0 behaves as 1 clock per bit
    start_frame(8'h96, 0, 0, 0, 0, "t6z");
    tx_valid_i = 1'b0;
    expect_frame(8'h96, 0, 0, 0, 0, "t6z", -1);

    // en_i dropped mid-frame: frame completes, no further accept
    start_frame(8'hE1, 2, 0, 0, 0, "t7");
    en_i = 1'b0;
    expect_frame(8'hE1, 2, 0, 0, 0, "t7", -1);
    repeat (3) @(negedge clk_i);
    check("t7_no_accept", {29'd0, tx_ready_o, tx_busy_o, tx_o}, 32'b001);
    tx_valid_i = 1'b0;
    en_i       = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
